// File: rtl/dnn_argmax_out.sv
// dnn_argmax_out: serial signed argmax, one compare per clock. Capture is edge 0 and out_valid rises after edge NumNerves-1.
// The result holds on valid/ready and no capture happens until the handshake. Define DNN_ARGMAX_RUNNER_UP_EN to add out_idx2/out_score2.
module dnn_argmax_out #(
  parameter int BitSize   = 8,
  parameter int NumNerves = 2,
  parameter int IdxBits   = (NumNerves > 1) ? $clog2(NumNerves) : 1,
  parameter int CountBits = 8
) (
  input  logic                              clk,
  input  logic                              res,
  input  logic                              in_valid,
  input  logic [NumNerves-1:0][BitSize-1:0] in_data,
  input  logic                              in_done,
  output logic                              in_ready,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [IdxBits-1:0]                out_idx,
  output logic [BitSize-1:0]                out_score,
  output logic                              out_last,
  output logic [CountBits-1:0]              out_count
`ifdef DNN_ARGMAX_RUNNER_UP_EN
  ,
  output logic [IdxBits-1:0]                out_idx2,
  output logic [BitSize-1:0]                out_score2
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, HOLD = 2'd2} state_t;

  localparam logic [IdxBits-1:0] LastIdx = IdxBits'(NumNerves - 1);

  state_t                              state_q, state_d;
  logic [NumNerves-1:0][BitSize-1:0]   vec_q, vec_d;
  logic [BitSize-1:0]                  best_q, best_d;
  logic [IdxBits-1:0]                  best_idx_q, best_idx_d;
  logic [IdxBits-1:0]                  scan_idx_q, scan_idx_d;
  logic                                pending_last_q, pending_last_d;
  logic [CountBits-1:0]                count_q, count_d;
  logic                                in_ready_q, in_ready_d;
  logic                                out_valid_q, out_valid_d;
  logic [BitSize-1:0]                  scan_elem;
  logic                                handshake;
`ifdef DNN_ARGMAX_RUNNER_UP_EN
  localparam logic [BitSize-1:0] MinScore = BitSize'(1) << (BitSize - 1);
  logic [BitSize-1:0]                  best2_q, best2_d;
  logic [IdxBits-1:0]                  best2_idx_q, best2_idx_d;
`endif

  // Mux-by-compare keeps the select in range for any NumNerves.
  always_comb begin
    scan_elem = '0;
    for (int k = 0; k < NumNerves; k++) begin
      if (scan_idx_q == IdxBits'(k)) scan_elem = vec_q[k];
    end
  end

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    scan_idx_d = scan_idx_q;
    count_d    = count_q;
    handshake  = 1'b0;
`ifdef DNN_ARGMAX_RUNNER_UP_EN
    best2_d     = best2_q;
    best2_idx_d = best2_idx_q;
`endif
    case (state_q)
      SCAN: begin
        if ($signed(scan_elem) > $signed(best_q)) begin
`ifdef DNN_ARGMAX_RUNNER_UP_EN
          best2_d     = best_q;
          best2_idx_d = best_idx_q;
`endif
          best_d     = scan_elem;
          best_idx_d = scan_idx_q;
        end
`ifdef DNN_ARGMAX_RUNNER_UP_EN
        else if ($signed(scan_elem) > $signed(best2_q)) begin
          best2_d     = scan_elem;
          best2_idx_d = scan_idx_q;
        end
`endif
        if (scan_idx_q == LastIdx) state_d = HOLD;
        else                       scan_idx_d = scan_idx_q + 1'b1;
      end
      HOLD: begin
        if (out_ready) begin
          handshake = 1'b1;
          state_d   = IDLE;
          count_d   = count_q + 1'b1;
        end
      end
      default: begin  // IDLE, and any unused encoding recovers here
        state_d = IDLE;
        if (in_valid) begin
          vec_d      = in_data;
          best_d     = in_data[0];
          best_idx_d = '0;
          scan_idx_d = IdxBits'(1);
`ifdef DNN_ARGMAX_RUNNER_UP_EN
          best2_d     = MinScore;
          best2_idx_d = '0;
`endif
          state_d = (NumNerves == 1) ? HOLD : SCAN;
        end
      end
    endcase
    // A done pulse on the handshake edge belongs to the next result.
    pending_last_d = in_done | (pending_last_q & ~handshake);
    in_ready_d     = (state_d == IDLE);
    out_valid_d    = (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q        <= IDLE;
      vec_q          <= '0;
      best_q         <= '0;
      best_idx_q     <= '0;
      scan_idx_q     <= '0;
      pending_last_q <= 1'b0;
      count_q        <= '0;
      in_ready_q     <= 1'b1;
      out_valid_q    <= 1'b0;
`ifdef DNN_ARGMAX_RUNNER_UP_EN
      best2_q        <= '0;
      best2_idx_q    <= '0;
`endif
    end else begin
      state_q        <= state_d;
      vec_q          <= vec_d;
      best_q         <= best_d;
      best_idx_q     <= best_idx_d;
      scan_idx_q     <= scan_idx_d;
      pending_last_q <= pending_last_d;
      count_q        <= count_d;
      in_ready_q     <= in_ready_d;
      out_valid_q    <= out_valid_d;
`ifdef DNN_ARGMAX_RUNNER_UP_EN
      best2_q        <= best2_d;
      best2_idx_q    <= best2_idx_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_idx   = best_idx_q;
  assign out_score = best_q;
  assign out_last  = out_valid_q & pending_last_q;
  assign out_count = count_q;
`ifdef DNN_ARGMAX_RUNNER_UP_EN
  assign out_idx2   = best2_idx_q;
  assign out_score2 = best2_q;
`endif

endmodule
